motion_segment_sequencer: RTL and testbench
===========================================

Name: motion_segment_sequencer

Overview:
Sequences one acceleration-profile generator channel from a stream of motion segments. Each segment carries optional x/v/a/j values and a length counted in acc_step ticks.
- Accepts segments over a valid/ready interface and loads them into the generator with load/set_* for one cycle.
- Issues acc_step at a programmable clock-divided rate and counts down the segment length.
- Handles host abort, plus auto-abort on queue underrun while the axis is moving.
- Sits between the per-axis segment FIFO and the profile generator.

Parameters:
DIV_W, 16, width of step_div and the tick divider counter
LEN_W, 32, width of seg_len and the remaining-tick counter

Ports:
clk  in  1  system clock
reset  in  1  synchronous active-high reset
step_div  in  DIV_W  clocks per acc_step tick; 0 treated as 1
seg_valid  in  1  segment available
seg_ready  out  1  segment accepted this cycle
seg_flags  in  4  {set_x, set_v, set_a, set_j}
seg_x  in  64  signed x value
seg_v  in  32  signed v value
seg_a  in  32  signed a value
seg_j  in  32  signed j value
seg_len  in  LEN_W  ticks to run segment
abort_req  in  1  level; request controlled stop
abort_a  in  32  signed abort deceleration, passed to generator
clear  in  1  pulse; leave HALT
pg_v, pg_a, pg_j  in  32 each  generator current v/a/j
pg_stopped  in  1  generator stopped flag
pg_load, pg_set_x, pg_set_v, pg_set_a, pg_set_j  out  1 each  generator load strobes
pg_x_val  out  64; pg_v_val, pg_a_val, pg_j_val  out  32 each  generator load values
pg_acc_step  out  1  tick strobe
pg_abort  out  1  generator abort level
pg_abort_a_val  out  32  equals abort_a (combinational pass-through)
busy  out  1  state != IDLE and != HALT
seg_done  out  1  one-cycle pulse when a segment's last tick issues
underrun  out  1  sticky; set on auto-abort, cleared by clear or reset

Behaviour:
- Reset: state IDLE; all registered outputs 0; divider 0; remaining 0.
- States: IDLE, LOAD, RUN, ABORT, HALT.
- IDLE:
  - seg_valid -> seg_ready=1 combinationally in the same cycle; latch fields; go to LOAD.
  - abort_req -> ABORT.
- LOAD (exactly 1 cycle):
  - pg_load=1 with pg_set_* = latched flags and pg_*_val = latched values.
  - No acc_step; divider cleared to 0.
  - remaining <= seg_len.
  - seg_len=0 -> boundary handling next cycle; otherwise -> RUN.
- RUN: divider counts 0..max(step_div,1)-1. At terminal count:
  - pg_acc_step=1 for one cycle; remaining decrements.
  - The tick that takes remaining to 0 also pulses seg_done.
- Boundary (cycle after the last tick, or after LOAD with seg_len=0):
  - seg_valid -> accept (seg_ready=1) and go to LOAD; one idle clock between segments.
  - No seg_valid, pg_v=pg_a=pg_j=0 -> IDLE.
  - No seg_valid, any nonzero -> set underrun; go to ABORT.
- ABORT:
  - pg_abort=1; ticks continue at the divider rate; seg_ready=0.
  - pg_stopped sampled 1 -> HALT.
- HALT:
  - pg_abort=0, no ticks, seg_ready=0.
  - clear=1 and abort_req=0 -> IDLE; underrun clears on clear.
- abort_req in LOAD or RUN -> ABORT next cycle. A load in progress completes; the remaining count is discarded.
- Priority: reset > abort_req > boundary/segment logic. pg_load and pg_acc_step are never high in the same cycle.
- step_div changes take effect at the next divider wrap.

Optional Feature:
Macro SEQ_UNDERRUN_COUNT_EN.
- Defined: adds output underrun_cnt[15:0], saturating at 0xFFFF. It increments on each auto-abort and clears only on reset.
- Undefined: port absent; only the sticky underrun flag exists.

Decomposition:
- Shared package seq_pkg: state encoding constants (IDLE=0, LOAD=1, RUN=2, ABORT=3, HALT=4), seg_flags bit indices, DIV_W/LEN_W defaults.
- One natural sub-module, seq_tick_div: divider with clear, enable and step_div input, producing a one-cycle tick.

Test Plan:
- step_div=4; one segment, flags=v|a, v=0, a=10, len=3 -> one pg_load cycle; ticks every 4 clocks; 3 ticks; seg_done on the 3rd tick; then ABORT (pg_v nonzero) with underrun=1.
- Two back-to-back segments, len=2 each, second ends with pg_v=pg_a=pg_j=0 -> loads separated by exactly 1 non-tick cycle; 4 total ticks; returns to IDLE with underrun=0.
- seg_len=0 segment followed by a len=1 segment -> two consecutive loads one cycle apart; no tick between them.
- abort_req raised mid-RUN with pg_stopped driven high 5 ticks later -> pg_abort=1 for those ticks; HALT; seg_ready=0 until clear with abort_req=0.
- step_div=0 -> tick every cycle in RUN.
- Reset asserted mid-ABORT -> next cycle IDLE with all outputs 0.
- SEQ_UNDERRUN_COUNT_EN: three forced underruns -> underrun_cnt=3; clear leaves the count at 3.

Source files
------------

// File: rtl/seq_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | seq_pkg: shared types and constants for motion_segment_sequencer    |
// | Rev 1.0                                                             |
// +--------------------------------------------------------------------+
package seq_pkg;

  localparam int DIV_W_DEF = 16;
  localparam int LEN_W_DEF = 32;

  localparam logic [2:0] ST_IDLE  = 3'd0;
  localparam logic [2:0] ST_LOAD  = 3'd1;
  localparam logic [2:0] ST_RUN   = 3'd2;
  localparam logic [2:0] ST_ABORT = 3'd3;
  localparam logic [2:0] ST_HALT  = 3'd4;

  // seg_flags = {set_x, set_v, set_a, set_j}
  localparam int FLG_J = 0;
  localparam int FLG_A = 1;
  localparam int FLG_V = 2;
  localparam int FLG_X = 3;

  typedef struct packed {
    logic [3:0]  flags;
    logic [63:0] x;
    logic [31:0] v;
    logic [31:0] a;
    logic [31:0] j;
  } seg_t;

endpackage
`default_nettype wire

// File: rtl/seq_tick_div.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | seq_tick_div: clock divider emitting a one-cycle tick every         |
// | max(step_div,1) enabled clocks. Rev 1.0                             |
// +--------------------------------------------------------------------+
module seq_tick_div
  import seq_pkg::*;
#(
  parameter int DIV_W = DIV_W_DEF
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             clr,
  input  logic             en,
  input  logic [DIV_W-1:0] step_div,
  output logic             tick
);

  logic [DIV_W-1:0] r_cnt;
  logic [DIV_W-1:0] r_lim;
  logic [DIV_W-1:0] w_lim_next;
  logic             w_wrap;

  // The terminal count is only refreshed on clear or wrap, so a new
  // step_div never truncates a period already in progress.
  assign w_lim_next = (step_div == '0) ? '0 : step_div - DIV_W'(1);
  assign w_wrap     = en && (r_cnt == r_lim);
  assign tick       = w_wrap;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_cnt <= '0;
      r_lim <= '0;
    end else if (clr) begin
      r_cnt <= '0;
      r_lim <= w_lim_next;
    end else if (w_wrap) begin
      r_cnt <= '0;
      r_lim <= w_lim_next;
    end else if (en) begin
      r_cnt <= r_cnt + DIV_W'(1);
    end
  end

endmodule
`default_nettype wire

// File: rtl/motion_segment_sequencer.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | motion_segment_sequencer: feeds motion segments into one profile    |
// | generator channel. Optional macro: SEQ_UNDERRUN_COUNT_EN. Rev 1.0   |
// +--------------------------------------------------------------------+
module motion_segment_sequencer
  import seq_pkg::*;
#(
  parameter int DIV_W = DIV_W_DEF,
  parameter int LEN_W = LEN_W_DEF
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [DIV_W-1:0]   step_div,
  input  logic               seg_valid,
  output logic               seg_ready,
  input  logic [3:0]         seg_flags,
  input  logic signed [63:0] seg_x,
  input  logic signed [31:0] seg_v,
  input  logic signed [31:0] seg_a,
  input  logic signed [31:0] seg_j,
  input  logic [LEN_W-1:0]   seg_len,
  input  logic               abort_req,
  input  logic signed [31:0] abort_a,
  input  logic               clear,
  input  logic signed [31:0] pg_v,
  input  logic signed [31:0] pg_a,
  input  logic signed [31:0] pg_j,
  input  logic               pg_stopped,
  output logic               pg_load,
  output logic               pg_set_x,
  output logic               pg_set_v,
  output logic               pg_set_a,
  output logic               pg_set_j,
  output logic signed [63:0] pg_x_val,
  output logic signed [31:0] pg_v_val,
  output logic signed [31:0] pg_a_val,
  output logic signed [31:0] pg_j_val,
  output logic               pg_acc_step,
  output logic               pg_abort,
  output logic signed [31:0] pg_abort_a_val,
  output logic               busy,
  output logic               seg_done,
  output logic               underrun
`ifdef SEQ_UNDERRUN_COUNT_EN
  , output logic [15:0]      underrun_cnt
`endif
);

  logic [2:0]       r_state;
  seg_t             r_seg;
  logic [LEN_W-1:0] r_len;
  logic [LEN_W-1:0] r_rem;
  logic             r_underrun;

  logic w_bnd, w_accept, w_moving, w_auto_abort;
  logic w_div_en, w_div_clr, w_tick;

  // A RUN cycle with nothing left to count is the inter-segment boundary.
  assign w_bnd        = (r_state == ST_RUN) && (r_rem == '0);
  assign w_accept     = seg_valid && !abort_req && ((r_state == ST_IDLE) || w_bnd);
  assign w_moving     = (pg_v != '0) || (pg_a != '0) || (pg_j != '0);
  assign w_auto_abort = w_bnd && !seg_valid && !abort_req && w_moving;
  assign w_div_en     = ((r_state == ST_RUN) && (r_rem != '0)) || (r_state == ST_ABORT);
  assign w_div_clr    = (r_state == ST_IDLE) || (r_state == ST_LOAD) || (r_state == ST_HALT);

  seq_tick_div #(.DIV_W(DIV_W)) u_div (
    .clk      (clk),
    .reset    (reset),
    .clr      (w_div_clr),
    .en       (w_div_en),
    .step_div (step_div),
    .tick     (w_tick)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state    <= ST_IDLE;
      r_seg      <= '0;
      r_len      <= '0;
      r_rem      <= '0;
      r_underrun <= 1'b0;
    end else begin
      if (w_accept) begin
        r_seg <= '{flags: seg_flags, x: seg_x, v: seg_v, a: seg_a, j: seg_j};
        r_len <= seg_len;
      end
      if (clear)        r_underrun <= 1'b0;
      if (w_auto_abort) r_underrun <= 1'b1;

      case (r_state)
        ST_IDLE: begin
          if (abort_req)      r_state <= ST_ABORT;
          else if (seg_valid) r_state <= ST_LOAD;
        end
        ST_LOAD: begin
          r_rem   <= abort_req ? '0 : r_len;
          r_state <= abort_req ? ST_ABORT : ST_RUN;
        end
        ST_RUN: begin
          if (abort_req) begin
            r_rem   <= '0;
            r_state <= ST_ABORT;
          end else if (w_bnd) begin
            if (seg_valid)     r_state <= ST_LOAD;
            else if (w_moving) r_state <= ST_ABORT;
            else               r_state <= ST_IDLE;
          end else if (w_tick) begin
            r_rem <= r_rem - LEN_W'(1);
          end
        end
        ST_ABORT: begin
          if (pg_stopped) r_state <= ST_HALT;
        end
        ST_HALT: begin
          if (clear && !abort_req) r_state <= ST_IDLE;
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

`ifdef SEQ_UNDERRUN_COUNT_EN
  logic [15:0] r_ucnt;
  always_ff @(posedge clk) begin
    if (reset)                                   r_ucnt <= '0;
    else if (w_auto_abort && r_ucnt != 16'hFFFF) r_ucnt <= r_ucnt + 16'd1;
  end
  assign underrun_cnt = r_ucnt;
`endif

  assign seg_ready      = w_accept;
  assign pg_load        = (r_state == ST_LOAD);
  assign pg_set_x       = pg_load && r_seg.flags[FLG_X];
  assign pg_set_v       = pg_load && r_seg.flags[FLG_V];
  assign pg_set_a       = pg_load && r_seg.flags[FLG_A];
  assign pg_set_j       = pg_load && r_seg.flags[FLG_J];
  assign pg_x_val       = r_seg.x;
  assign pg_v_val       = r_seg.v;
  assign pg_a_val       = r_seg.a;
  assign pg_j_val       = r_seg.j;
  assign pg_acc_step    = w_tick;
  assign pg_abort       = (r_state == ST_ABORT);
  assign pg_abort_a_val = abort_a;
  assign busy           = (r_state != ST_IDLE) && (r_state != ST_HALT);
  assign seg_done       = w_tick && (r_state == ST_RUN) && (r_rem == LEN_W'(1));
  assign underrun       = r_underrun;

endmodule
`default_nettype wire

// File: tb/tb_motion_segment_sequencer.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | tb_motion_segment_sequencer: directed + random segment streams      |
// | checked against cycle-arithmetic expectations. Rev 1.0              |
// +--------------------------------------------------------------------+
module tb_motion_segment_sequencer;

  typedef struct {
    logic [3:0]  f;
    logic [63:0] x;
    logic [31:0] v, a, j;
    int          len;
  } tb_seg_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset = 1'b1;
  logic [15:0] step_div = 16'd1;
  logic        seg_valid = 1'b0;
  logic        seg_ready;
  logic [3:0]  seg_flags = '0;
  logic [63:0] seg_x = '0;
  logic [31:0] seg_v = '0, seg_a = '0, seg_j = '0;
  logic [31:0] seg_len = '0;
  logic        abort_req = 1'b0;
  logic [31:0] abort_a = 32'hFFFF_FF80;
  logic        clear = 1'b0;
  logic [31:0] pg_v = '0, pg_a = '0, pg_j = '0;
  logic        pg_stopped = 1'b0;
  logic        pg_load, pg_set_x, pg_set_v, pg_set_a, pg_set_j;
  logic [63:0] pg_x_val;
  logic [31:0] pg_v_val, pg_a_val, pg_j_val, pg_abort_a_val;
  logic        pg_acc_step, pg_abort, busy, seg_done, underrun;
`ifdef SEQ_UNDERRUN_COUNT_EN
  logic [15:0] underrun_cnt;
`endif

  motion_segment_sequencer dut (
    .clk(clk), .reset(reset), .step_div(step_div),
    .seg_valid(seg_valid), .seg_ready(seg_ready), .seg_flags(seg_flags),
    .seg_x(seg_x), .seg_v(seg_v), .seg_a(seg_a), .seg_j(seg_j), .seg_len(seg_len),
    .abort_req(abort_req), .abort_a(abort_a), .clear(clear),
    .pg_v(pg_v), .pg_a(pg_a), .pg_j(pg_j), .pg_stopped(pg_stopped),
    .pg_load(pg_load), .pg_set_x(pg_set_x), .pg_set_v(pg_set_v),
    .pg_set_a(pg_set_a), .pg_set_j(pg_set_j),
    .pg_x_val(pg_x_val), .pg_v_val(pg_v_val), .pg_a_val(pg_a_val), .pg_j_val(pg_j_val),
    .pg_acc_step(pg_acc_step), .pg_abort(pg_abort), .pg_abort_a_val(pg_abort_a_val),
    .busy(busy), .seg_done(seg_done), .underrun(underrun)
`ifdef SEQ_UNDERRUN_COUNT_EN
    , .underrun_cnt(underrun_cnt)
`endif
  );

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Event monitor
  bit      rec = 0;
  int      mon_load[$], mon_tick[$], mon_done[$];
  tb_seg_t mon_seg[$];
  always @(negedge clk) begin
    if (pg_load) check("load_tick_exclusive", pg_acc_step, 0);
    if (rec) begin
      if (pg_load) begin
        mon_load.push_back(cyc);
        mon_seg.push_back('{f: {pg_set_x, pg_set_v, pg_set_a, pg_set_j}, x: pg_x_val,
                            v: pg_v_val, a: pg_a_val, j: pg_j_val, len: 0});
      end
      if (pg_acc_step) mon_tick.push_back(cyc);
      if (seg_done)    mon_done.push_back(cyc);
    end
  end

  tb_seg_t segs[$];
  int      exp_load[$], exp_tick[$], exp_done[$];

  task automatic cmp_events(input string tag, input int which, input int a0, input int b);
    int act[$];
    int ex[$];
    act.delete();
    case (which)
      0: begin foreach (mon_load[i]) if (mon_load[i] - a0 <= b) act.push_back(mon_load[i] - a0); ex = exp_load; end
      1: begin foreach (mon_tick[i]) if (mon_tick[i] - a0 <= b) act.push_back(mon_tick[i] - a0); ex = exp_tick; end
      default: begin foreach (mon_done[i]) if (mon_done[i] - a0 <= b) act.push_back(mon_done[i] - a0); ex = exp_done; end
    endcase
    check({tag, "_count"}, act.size(), ex.size());
    for (int i = 0; i < ex.size() && i < act.size(); i++)
      check({tag, "_cycle"}, act[i], ex[i]);
  endtask

  // Drive the queued segments back-to-back and compare load/tick/done timing
  // with L0 = accept+1, ticks every max(div,1) clocks, next load two clocks
  // after a segment's last tick (or after its load when len=0).
  task automatic run_stream(input int div, input bit moving);
    int d, l, b, idx, a0;
    bit ok;
    d = (div == 0) ? 1 : div;
    l = 1; b = 0;
    exp_load.delete(); exp_tick.delete(); exp_done.delete();
    foreach (segs[i]) begin
      exp_load.push_back(l);
      for (int m = 1; m <= segs[i].len; m++) exp_tick.push_back(l + d * m);
      if (segs[i].len > 0) exp_done.push_back(l + d * segs[i].len);
      b = l + d * segs[i].len + 1;
      l = b + 1;
    end
    step_div = 16'(div);
    pg_v = moving ? 32'd7 : 32'd0; pg_a = '0; pg_j = '0;
    mon_load.delete(); mon_tick.delete(); mon_done.delete(); mon_seg.delete();
    rec = 1; idx = 0; a0 = -1; ok = 0;
    for (int n = 0; n < 2000 && !ok; n++) begin
      @(negedge clk);
      if (idx < segs.size()) begin
        seg_valid = 1'b1; seg_flags = segs[idx].f; seg_x = segs[idx].x;
        seg_v = segs[idx].v; seg_a = segs[idx].a; seg_j = segs[idx].j;
        seg_len = 32'(segs[idx].len);
      end else begin
        seg_valid = 1'b0;
      end
      #1;
      if (seg_valid && seg_ready) begin
        if (idx == 0) a0 = cyc;
        idx++;
      end
      if (idx == segs.size() && a0 >= 0 && cyc >= a0 + b + 1) ok = 1;
    end
    seg_valid = 1'b0;
    rec = 0;
    check("stream_completed", ok, 1);
    cmp_events("load", 0, a0, b);
    cmp_events("tick", 1, a0, b);
    cmp_events("done", 2, a0, b);
    for (int i = 0; i < segs.size() && i < mon_seg.size(); i++) begin
      check("load_flags", mon_seg[i].f, segs[i].f);
      check("load_x", mon_seg[i].x, segs[i].x);
      check("load_v", mon_seg[i].v, segs[i].v);
      check("load_a", mon_seg[i].a, segs[i].a);
      check("load_j", mon_seg[i].j, segs[i].j);
    end
    // Cycle after the final boundary: IDLE if stopped, auto-abort if moving.
    check("post_busy", busy, moving);
    check("post_abort", pg_abort, moving);
    check("post_underrun", underrun, moving);
    if (moving) begin
      pg_stopped = 1'b1;
      @(negedge clk);
      check("halt_abort_low", pg_abort, 0);
      check("halt_busy", busy, 0);
      check("halt_underrun_held", underrun, 1);
      seg_valid = 1'b1; #1;
      check("halt_no_ready", seg_ready, 0);
      seg_valid = 1'b0; clear = 1'b1; pg_stopped = 1'b0;
      @(negedge clk);
      clear = 1'b0;
      check("clear_underrun", underrun, 0);
      check("clear_idle_busy", busy, 0);
    end
    pg_v = '0;
  endtask

  task automatic add_seg(input logic [3:0] f, input logic [31:0] v, input logic [31:0] a, input int len);
    segs.push_back('{f: f, x: {$urandom, $urandom}, v: v, a: a, j: $urandom, len: len});
  endtask

  initial begin
    int tk, last;
    bit got;
    repeat (3) @(negedge clk);
    check("rst_busy", busy, 0);
    check("rst_ready", seg_ready, 0);
    check("rst_load", pg_load, 0);
    check("rst_abort", pg_abort, 0);
    check("rst_underrun", underrun, 0);
    check("rst_xval", pg_x_val, 0);
    check("rst_tick", pg_acc_step, 0);
    reset = 1'b0;
    @(negedge clk);
    check("abort_a_passthru", pg_abort_a_val, 32'hFFFF_FF80);

    // Single segment then underrun (generator still moving).
    segs.delete(); add_seg(4'b0110, 32'd0, 32'd10, 3);
    run_stream(4, 1);
    // Two back-to-back segments ending at rest.
    segs.delete(); add_seg(4'b1111, $urandom, $urandom, 2); add_seg(4'b0001, $urandom, $urandom, 2);
    run_stream(3, 0);
    // Zero-length segment followed by one tick.
    segs.delete(); add_seg(4'b1000, $urandom, $urandom, 0); add_seg(4'b0100, $urandom, $urandom, 1);
    run_stream(2, 0);
    // step_div=0 behaves as 1.
    segs.delete(); add_seg(4'b0010, $urandom, $urandom, 3);
    run_stream(0, 0);
    // Random streams.
    for (int s = 0; s < 4; s++) begin
      segs.delete();
      for (int k = 0; k < int'($urandom_range(1, 4)); k++)
        add_seg(4'($urandom), $urandom, $urandom, int'($urandom_range(0, 4)));
      run_stream(int'($urandom_range(0, 4)), bit'($urandom_range(0, 1)));
    end

    // Host abort mid-RUN.
    step_div = 16'd2;
    @(negedge clk);
    seg_valid = 1'b1; seg_flags = 4'b1000; seg_x = 64'h1234_5678_9ABC_DEF0; seg_len = 32'd20;
    #1 check("abort_idle_ready", seg_ready, 1);
    @(negedge clk);
    seg_valid = 1'b0;
    check("abort_load", pg_load, 1);
    tk = 0; last = 0;
    for (int n = 0; n < 50 && tk < 3; n++) begin
      @(negedge clk);
      if (pg_acc_step) begin tk++; last = cyc; end
    end
    check("run_three_ticks", tk, 3);
    abort_req = 1'b1;
    @(negedge clk);
    check("abort_entered", pg_abort, 1);
    check("abort_busy", busy, 1);
    tk = 0;
    for (int n = 0; n < 50 && tk < 5; n++) begin
      if (pg_acc_step) begin
        check("abort_tick_spacing", cyc - last, 2);
        check("abort_tick_abort_high", pg_abort, 1);
        tk++; last = cyc;
      end
      if (tk < 5) @(negedge clk);
    end
    check("abort_five_ticks", tk, 5);
    pg_stopped = 1'b1;
    @(negedge clk);
    pg_stopped = 1'b0;
    check("halt_pg_abort", pg_abort, 0);
    check("halt_no_tick", pg_acc_step, 0);
    clear = 1'b1;
    repeat (2) @(negedge clk);
    check("halt_held_by_abort_req", pg_abort, 0);
    check("halt_held_busy", busy, 0);
    abort_req = 1'b0;
    @(negedge clk);
    clear = 1'b0;
    seg_valid = 1'b1; #1;
    check("released_idle_ready", seg_ready, 1);
    seg_valid = 1'b0;

    // Reset during ABORT.
    abort_req = 1'b1;
    @(negedge clk);
    check("idle_abort_entered", pg_abort, 1);
    reset = 1'b1; abort_req = 1'b0;
    @(negedge clk);
    reset = 1'b0;
    check("rst2_abort", pg_abort, 0);
    check("rst2_busy", busy, 0);
    check("rst2_xval", pg_x_val, 0);
    check("rst2_tick", pg_acc_step, 0);
    check("rst2_underrun", underrun, 0);

`ifdef SEQ_UNDERRUN_COUNT_EN
    check("ucnt_reset", underrun_cnt, 0);
    for (int u = 0; u < 3; u++) begin
      segs.delete(); add_seg(4'b0100, 32'd5, 32'd0, 1);
      run_stream(1, 1);
    end
    check("ucnt_three_after_clear", underrun_cnt, 3);
`endif

    got = 1;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
